// File: rtl/video_pkg.sv
// Shared raster geometry for the 320x240 display path; the timing generator
// and the framebuffer both take their dimensions from here.
package video_pkg;

  localparam int H_ACTIVE = 320;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 32;
  localparam int H_BP     = 32;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 240;
  localparam int V_FP     = 8;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 4;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned FB_LAT = 1;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 24;
  localparam int FCNT_W  = 16;

  localparam int FB_WIDTH  = H_ACTIVE;
  localparam int FB_HEIGHT = V_ACTIVE;

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register with synchronous clear; matches control signals
// to the framebuffer read latency.
module video_delay_line #(
  parameter int          W     = 3,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe <= '{default: '0};
    end else begin
      pipe[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/video_timing_out.sv
// Raster counters, sync/DE decode, latency-aligned video output register and
// CPU frame status for the 320x240 display path.
module video_timing_out
  import video_pkg::*;
#(
  parameter int          H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int          H_FP     = video_pkg::H_FP,
  parameter int          H_SYNC   = video_pkg::H_SYNC,
  parameter int          H_BP     = video_pkg::H_BP,
  parameter int          V_ACTIVE = video_pkg::V_ACTIVE,
  parameter int          V_FP     = video_pkg::V_FP,
  parameter int          V_SYNC   = video_pkg::V_SYNC,
  parameter int          V_BP     = video_pkg::V_BP,
  parameter int unsigned FB_LAT   = video_pkg::FB_LAT
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  input  logic [RGB_W-1:0]   pixel_color,
  output logic [RGB_W-1:0]   video_rgb,
  output logic               video_de,
  output logic               video_hs,
  output logic               video_vs,
  output logic               vblank,
  output logic               frame_irq,
  output logic [FCNT_W-1:0]  frame_count
);

  localparam int LINE_CLKS   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               h_last;
  logic               v_last;

  assign h_last = (h_cnt == COORD_W'(LINE_CLKS - 1));
  assign v_last = (v_cnt == COORD_W'(FRAME_LINES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end
    end
  end

  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;

  logic de0;
  logic hs0;
  logic vs0;

  assign de0 = (h_cnt < COORD_W'(H_ACTIVE)) && (v_cnt < COORD_W'(V_ACTIVE));
  assign hs0 = (h_cnt == COORD_W'(H_ACTIVE + H_FP));
  assign vs0 = hs0 && (v_cnt == COORD_W'(V_ACTIVE + V_FP));

  logic de_d;
  logic hs_d;
  logic vs_d;

  video_delay_line #(
    .W    (3),
    .DEPTH(FB_LAT)
  ) u_ctrl_delay (
    .clk    (clk),
    .reset_n(reset_n),
    .d      ({de0, hs0, vs0}),
    .q      ({de_d, hs_d, vs_d})
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      video_rgb <= '0;
      video_de  <= 1'b0;
      video_hs  <= 1'b0;
      video_vs  <= 1'b0;
    end else begin
      video_rgb <= de_d ? pixel_color : '0;
      video_de  <= de_d;
      video_hs  <= hs_d;
      video_vs  <= vs_d;
    end
  end

  assign vblank = (v_cnt >= COORD_W'(V_ACTIVE));

  // Decoded one clk early so the registered pulse and count land exactly
  // while the counters sit at (0, V_ACTIVE).
  logic              irq_next;
  logic [FCNT_W-1:0] frame_cnt;

  assign irq_next = h_last && (v_cnt == COORD_W'(V_ACTIVE - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_irq <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_irq <= irq_next;
      if (irq_next) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign frame_count = frame_cnt;

endmodule
